// File: rtl/mem_responder_if.sv
// mem_responder_if: request/acknowledge handshake of the CPU memory bus.
// The bidirectional data bus stays a plain inout port on the target.
interface mem_responder_if #(parameter int ADDR_W = 12);
    logic m_req;
    logic m_rw_;
    logic [ADDR_W-1:0] m_addr;
    logic m_ack;
    logic m_err;
    modport master (output m_req, m_rw_, m_addr, input m_ack, m_err);
    modport slave (input m_req, m_rw_, m_addr, output m_ack, m_err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with programmable wait states,
// one-cycle acknowledge, tristated read data and a side-band preload port.
module mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic clock,
    input  logic reset,
    mem_responder_if.slave bus,
    inout  wire [DATA_W-1:0] m_data,
    input  logic init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic busy
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;
    state_t state, next;
    logic [3:0] cnt;
    logic rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem [DEPTH];
    logic accept, addr_ok, preload, commit;
    assign addr_ok = 32'(addr) < DEPTH;
    assign preload = state == IDLE && init_we && 32'(init_addr) < DEPTH;
    assign commit = state == WAIT && cnt == '0 && !rw && addr_ok;
    assign busy = state != IDLE;
    assign m_data = (state == RESP && rw) ? (addr_ok ? mem[addr[IW-1:0]] : '0) : 'z;
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= next;
    // a preload in the same IDLE cycle defers the request
    always_comb begin
        next = state;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                accept = bus.m_req && !init_we;
                next = accept ? WAIT : IDLE;
            end
            WAIT: next = cnt == '0 ? RESP : WAIT;
            RESP: next = HOLD;
            HOLD: next = bus.m_req ? HOLD : IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cnt <= '0;
            rw <= 1'b0;
            addr <= '0;
            wdata <= '0;
            bus.m_ack <= 1'b0;
            bus.m_err <= 1'b0;
        end else begin
            bus.m_ack <= next == RESP;
            bus.m_err <= next == RESP && !addr_ok;
            if (accept) begin
                cnt <= 4'(WAIT_STATES);
                rw <= bus.m_rw_;
                addr <= bus.m_addr;
                if (!bus.m_rw_) wdata <= m_data;
            end else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
        end
    // array is never reset; writes commit on entry to RESP
    always_ff @(posedge clock)
        if (preload || commit)
            mem[preload ? init_addr[IW-1:0] : addr[IW-1:0]] <= preload ? init_data : wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three targets (WAIT_STATES 1, 0, 15) driven in lockstep,
// checked against directed vectors and a word-array reference model.
module tb_mem_responder;
    localparam logic [31:0] PARK = 32'h0;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0, rw = 1'b1, init_we = 1'b0, drv_en = 1'b1;
    logic [11:0] addr = '0, init_addr = '0;
    logic [31:0] init_data = '0, drv_val = PARK;
    logic ack [3];
    logic err [3];
    logic busy [3];
    logic [31:0] rd [3];
    int ws [3] = '{1, 0, 15};
    int errors = 0, checks = 0;
    logic [31:0] model [1024];

    typedef struct {
        int op;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic exp_err;
    } vec_t;
    vec_t tbl [13];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : u
        mem_responder_if #(.ADDR_W(12)) bus ();
        wire [31:0] data;
        assign bus.m_req = req;
        assign bus.m_rw_ = rw;
        assign bus.m_addr = addr;
        assign data = drv_en ? drv_val : 'z;
        assign ack[g] = bus.m_ack;
        assign err[g] = bus.m_err;
        assign rd[g] = data;
        mem_responder #(.WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : 15)) dut (
            .clock(clock), .reset(reset), .bus(bus.slave), .m_data(data),
            .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
            .busy(busy[g])
        );
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        init_we = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clock);
        init_we = 1'b0;
        if (a < 12'd1024) model[a[9:0]] = d;
    endtask

    task automatic txn(input logic r, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input logic exp_err, input string nm);
        bit done [3] = '{default: 1'b0};
        int left = 3;
        for (int g = 0; g < 3; g++)
            check($sformatf("%s idle_bus ws=%0d", nm, ws[g]), rd[g], drv_val);
        req = 1'b1;
        rw = r;
        addr = a;
        drv_en = 1'b1;
        drv_val = r ? PARK : wd;
        for (int c = 1; c <= 40 && left > 0; c++) begin
            @(negedge clock);
            for (int g = 0; g < 3; g++) begin
                if (!done[g] && ack[g]) begin
                    done[g] = 1'b1;
                    left--;
                    check($sformatf("%s latency ws=%0d", nm, ws[g]), 32'(c), 32'(ws[g] + 2));
                    check($sformatf("%s err ws=%0d", nm, ws[g]), 32'(err[g]), 32'(exp_err));
                    if (r) check($sformatf("%s rdata ws=%0d", nm, ws[g]), rd[g], exp);
                end else if (done[g]) begin
                    check($sformatf("%s single_ack ws=%0d", nm, ws[g]), 32'(ack[g]), 32'd0);
                end
            end
            // direction stays put, but address and write data wander after acceptance
            if (c == 1) begin
                addr = a ^ 12'h001;
                if (r) drv_en = 1'b0;
                else drv_val = ~wd;
            end
        end
        for (int g = 0; g < 3; g++)
            if (!done[g]) check($sformatf("%s ack_timeout ws=%0d", nm, ws[g]), 32'(done[g]), 32'd1);
        if (!r && !exp_err) model[a[9:0]] = wd;
        drv_en = 1'b1;
        drv_val = PARK;
        for (int h = 0; h < 2; h++) begin
            @(negedge clock);
            for (int g = 0; g < 3; g++) begin
                check($sformatf("%s hold_ack ws=%0d", nm, ws[g]), 32'(ack[g]), 32'd0);
                check($sformatf("%s hold_err ws=%0d", nm, ws[g]), 32'(err[g]), 32'd0);
                check($sformatf("%s hold_busy ws=%0d", nm, ws[g]), 32'(busy[g]), 32'd1);
                check($sformatf("%s hold_bus ws=%0d", nm, ws[g]), rd[g], PARK);
            end
        end
        req = 1'b0;
        rw = 1'($urandom);
        addr = 12'($urandom);
        @(negedge clock);
        for (int g = 0; g < 3; g++)
            check($sformatf("%s back_idle ws=%0d", nm, ws[g]), 32'(busy[g]), 32'd0);
    endtask

    initial begin
        tbl = '{
            '{0, 12'h005, 32'hDEADBEEF, 32'h0, 1'b0},
            '{2, 12'h005, 32'h0, 32'hDEADBEEF, 1'b0},
            '{1, 12'h010, 32'h00001234, 32'h0, 1'b0},
            '{2, 12'h010, 32'h0, 32'h00001234, 1'b0},
            '{0, 12'h3FF, 32'hCAFEF00D, 32'h0, 1'b0},
            '{2, 12'h400, 32'h0, 32'h0, 1'b1},
            '{1, 12'h7FF, 32'hFFFFFFFF, 32'h0, 1'b1},
            '{2, 12'h3FF, 32'h0, 32'hCAFEF00D, 1'b0},
            '{0, 12'h003, 32'h33333333, 32'h0, 1'b0},
            '{0, 12'h403, 32'h99999999, 32'h0, 1'b0},
            '{2, 12'h003, 32'h0, 32'h33333333, 1'b0},
            '{1, 12'h3FF, 32'h0BADCAFE, 32'h0, 1'b0},
            '{2, 12'h3FF, 32'h0, 32'h0BADCAFE, 1'b0}
        };
        repeat (3) @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset ack ws=%0d", ws[g]), 32'(ack[g]), 32'd0);
            check($sformatf("reset err ws=%0d", ws[g]), 32'(err[g]), 32'd0);
            check($sformatf("reset busy ws=%0d", ws[g]), 32'(busy[g]), 32'd0);
            check($sformatf("reset bus ws=%0d", ws[g]), rd[g], PARK);
        end
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 13; i++)
            if (tbl[i].op == 0) preload(tbl[i].a, tbl[i].d);
            else txn(tbl[i].op == 2, tbl[i].a, tbl[i].d, tbl[i].exp, tbl[i].exp_err,
                     $sformatf("vec%0d", i));

        // preload and request in the same IDLE cycle: preload first, request next edge
        init_we = 1'b1;
        init_addr = 12'h030;
        init_data = 32'h0BEEF030;
        req = 1'b1;
        rw = 1'b1;
        addr = 12'h030;
        @(negedge clock);
        for (int g = 0; g < 3; g++)
            check($sformatf("collide not_accepted ws=%0d", ws[g]), 32'(busy[g]), 32'd0);
        init_we = 1'b0;
        model[12'h030] = 32'h0BEEF030;
        txn(1'b1, 12'h030, 32'h0, 32'h0BEEF030, 1'b0, "collide");

        // reset during WAIT of a write aborts it
        preload(12'h020, 32'hAAAAAAAA);
        req = 1'b1;
        rw = 1'b0;
        addr = 12'h020;
        drv_val = 32'h55555555;
        @(negedge clock);
        for (int g = 0; g < 3; g++)
            check($sformatf("abort accepted ws=%0d", ws[g]), 32'(busy[g]), 32'd1);
        reset = 1'b1;
        drv_val = PARK;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("abort busy ws=%0d", ws[g]), 32'(busy[g]), 32'd0);
            check($sformatf("abort ack ws=%0d", ws[g]), 32'(ack[g]), 32'd0);
            check($sformatf("abort bus ws=%0d", ws[g]), rd[g], PARK);
        end
        @(negedge clock);
        reset = 1'b0;
        req = 1'b0;
        @(negedge clock);
        txn(1'b1, 12'h020, 32'h0, 32'hAAAAAAAA, 1'b0, "abort_read");

        // randomized traffic against the model
        for (int i = 0; i < 16; i++) preload(12'(i), $urandom);
        for (int i = 0; i < 50; i++) begin
            logic r;
            logic [11:0] a;
            logic [31:0] wd;
            logic e;
            r = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 15));
            wd = $urandom;
            e = a >= 12'd1024;
            if ($urandom_range(0, 4) == 0) preload(12'($urandom_range(0, 15)), $urandom);
            txn(r, a, wd, (r && !e) ? model[a[9:0]] : 32'h0, e, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
